// File: rtl/fft_pair_feeder.sv
// Ping-pong frame buffer feeding stage-0 butterfly operand pairs.
// Define FFT_FEEDER_BITREV_EN for bit-reversed (DIT) pairing; default is natural pairs.
module fft_pair_feeder #(
    parameter int unsigned DW = 32,
    parameter int unsigned N  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW-1:0]          in_real,
    input  logic [DW-1:0]          in_imag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          din0_real,
    output logic [DW-1:0]          din0_imag,
    output logic [DW-1:0]          din1_real,
    output logic [DW-1:0]          din1_imag,
    output logic [$clog2(N)-2:0]   out_pair_idx,
    output logic                   out_last
);

    localparam int unsigned LOG2N = $clog2(N);
    localparam int unsigned PW    = LOG2N - 1;
    localparam int unsigned EW    = 2 * DW;

    logic [EW-1:0]    mem_q [2*N];

    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic [1:0]       full_q, full_d;
    logic             rd_bank_q, rd_bank_d;
    logic [PW-1:0]    rd_cnt_q, rd_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [PW-1:0]    out_pair_idx_q, out_pair_idx_d;
    logic [DW-1:0]    din0_real_q, din0_real_d, din0_imag_q, din0_imag_d;
    logic [DW-1:0]    din1_real_q, din1_real_d, din1_imag_q, din1_imag_d;

    logic             accept_c, wr_last_c, hs_c, last_hs_c, load_c, rd_bank_sel_c;
    logic [PW-1:0]    pair_sel_c;
    logic [LOG2N:0]   rd_addr0_c, rd_addr1_c;
    logic [EW-1:0]    rd_data0_c, rd_data1_c;

    // Maps a position within the pair stream to a buffer address.
    function automatic logic [LOG2N-1:0] addr_map(input logic [LOG2N-1:0] j);
`ifdef FFT_FEEDER_BITREV_EN
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = j[LOG2N-1-i];
        end
        return r;
`else
        return j;
`endif
    endfunction

    assign in_ready = rst_n & ~full_q[wr_bank_q];

    always_comb begin
        accept_c       = in_valid & in_ready;
        wr_last_c      = (wr_cnt_q == LOG2N'(N - 1));
        hs_c           = out_valid_q & out_ready;
        last_hs_c      = hs_c & out_last_q;

        wr_cnt_d       = wr_cnt_q;
        wr_bank_d      = wr_bank_q;
        full_d         = full_q;
        rd_bank_d      = rd_bank_q;
        rd_cnt_d       = rd_cnt_q;
        out_valid_d    = out_valid_q;
        out_last_d     = out_last_q;
        out_pair_idx_d = out_pair_idx_q;
        din0_real_d    = din0_real_q;
        din0_imag_d    = din0_imag_q;
        din1_real_d    = din1_real_q;
        din1_imag_d    = din1_imag_q;

        if (accept_c) begin
            wr_cnt_d = wr_cnt_q + LOG2N'(1);
            if (wr_last_c) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        // Finishing a frame hands the read side to the other bank on the same edge.
        rd_bank_sel_c = last_hs_c ? ~rd_bank_q : rd_bank_q;
        pair_sel_c    = last_hs_c ? '0 : rd_cnt_q;
        if (last_hs_c) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = rd_bank_sel_c;
            rd_cnt_d          = '0;
        end

        rd_addr0_c = {rd_bank_sel_c, addr_map({pair_sel_c, 1'b0})};
        rd_addr1_c = {rd_bank_sel_c, addr_map({pair_sel_c, 1'b1})};
        rd_data0_c = mem_q[rd_addr0_c];
        rd_data1_c = mem_q[rd_addr1_c];

        load_c = full_q[rd_bank_sel_c] &
                 (last_hs_c | ~out_valid_q | (out_ready & ~out_last_q));

        if (load_c) begin
            out_valid_d    = 1'b1;
            out_pair_idx_d = pair_sel_c;
            out_last_d     = (pair_sel_c == PW'(N / 2 - 1));
            rd_cnt_d       = pair_sel_c + PW'(1);
            {din0_real_d, din0_imag_d} = rd_data0_c;
            {din1_real_d, din1_imag_d} = rd_data1_c;
        end else if (hs_c) begin
            out_valid_d    = 1'b0;
            out_pair_idx_d = '0;
            out_last_d     = 1'b0;
        end
    end

    // Sample storage is never reset; the full flags alone qualify its contents.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            mem_q[{wr_bank_q, wr_cnt_q}] <= {in_real, in_imag};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt_q       <= '0;
            wr_bank_q      <= 1'b0;
            full_q         <= '0;
            rd_bank_q      <= 1'b0;
            rd_cnt_q       <= '0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            out_pair_idx_q <= '0;
            din0_real_q    <= '0;
            din0_imag_q    <= '0;
            din1_real_q    <= '0;
            din1_imag_q    <= '0;
        end else begin
            wr_cnt_q       <= wr_cnt_d;
            wr_bank_q      <= wr_bank_d;
            full_q         <= full_d;
            rd_bank_q      <= rd_bank_d;
            rd_cnt_q       <= rd_cnt_d;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            out_pair_idx_q <= out_pair_idx_d;
            din0_real_q    <= din0_real_d;
            din0_imag_q    <= din0_imag_d;
            din1_real_q    <= din1_real_d;
            din1_imag_q    <= din1_imag_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign out_pair_idx = out_pair_idx_q;
    assign din0_real    = din0_real_q;
    assign din0_imag    = din0_imag_q;
    assign din1_real    = din1_real_q;
    assign din1_imag    = din1_imag_q;

endmodule

// File: doc/fft_pair_feeder.md
FFT_PAIR_FEEDER -- requirements
Module: fft_pair_feeder

Interface
REQ-001 The block SHALL have parameter DW, default 32, which sets the width of each real and imaginary component.
REQ-002 The block SHALL have parameter N, default 32, which sets the points per frame; N is a power of two from 4 to 64, and LOG2N = log2(N).
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: the input sample is valid.
REQ-006 Port in_ready, output, 1 bit: the block can accept an input sample.
REQ-007 Port in_real / in_imag, input, DW bits each: input sample in natural time order.
REQ-008 Port out_valid, output, 1 bit: the butterfly operand pair is valid.
REQ-009 Port out_ready, input, 1 bit: the downstream butterfly consumes the pair.
REQ-010 Port din0_real / din0_imag / din1_real / din1_imag, output, DW bits each: butterfly operands.
REQ-011 Port out_pair_idx, output, LOG2N-1 bits: index k of the pair within the frame.
REQ-012 Port out_last, output, 1 bit: the pair is the final pair of the frame (k = N/2-1).

Function
REQ-013 The block SHALL be the input stage to butterfly_32b: it buffers N-sample frames and issues N/2 operand pairs for stage 0.
REQ-014 Storage SHALL be two N-entry banks used ping-pong, each bank with a full flag.
REQ-015 Input handshake: a sample is accepted on a rising edge with in_valid=1 and in_ready=1.
  - in_ready = NOT full[wr_bank].
  - The accepted sample is written at address wr_cnt, and wr_cnt then increments.
REQ-016 On acceptance with wr_cnt = N-1, the block SHALL set full[wr_bank], toggle wr_bank and clear wr_cnt to 0.
REQ-017 Output register SHALL load when full[rd_bank]=1, pairs remain in the frame, and either out_valid=0 or out_ready=1.
  - Load sets out_valid=1 and writes the pair for rd_cnt.
  - Bank memory is read combinationally into this register.
REQ-018 Latency: a frame completing on edge E SHALL give out_valid=1 after edge E+1, provided the read side is idle.
REQ-019 Throughput SHALL be one pair per cycle while out_ready=1 is held.
REQ-020 A pair SHALL be held stable while out_valid=1 and out_ready=0.
REQ-021 Pair k SHALL be din0 = x[A(2k)] and din1 = x[A(2k+1)], where A is defined in Configuration.
REQ-022 On handshake of the out_last pair, the block SHALL:
  - clear full[rd_bank];
  - toggle rd_bank;
  - reset rd_cnt to 0;
  - drop out_valid if the next bank is not full, otherwise load its pair 0 on the same edge.
REQ-023 A write to one bank and a read of the other in the same cycle SHALL both proceed.
REQ-024 When both banks are full, in_ready SHALL be 0 until the last-pair handshake.
  - in_ready rises after that edge, not combinationally.
REQ-025 When out_valid=0, out_pair_idx and out_last SHALL be 0, and data outputs SHALL hold their last value.

Reset
REQ-026 While rst_n=0 at a rising edge, the block SHALL:
  - clear wr_cnt, rd_cnt, wr_bank, rd_bank and both full flags;
  - set out_valid=0, out_last=0, out_pair_idx=0 and all din outputs to 0.
REQ-027 in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.
REQ-028 Reset mid-frame SHALL discard all partially written and buffered frames; bank memory contents need not be cleared.

Configuration
REQ-029 Macro FFT_FEEDER_BITREV_EN SHALL select the address mapping.
  - Defined: A(j) = bit-reverse of j over LOG2N bits, giving decimation-in-time stage 0 ordering.
  - Undefined: A(j) = j, giving natural adjacent pairs.

Verification
REQ-030 Bit-reverse mode, N=32, frame x[i] = (real=i, imag=0x100+i), out_ready=1, expected pairs:
  - k=0: din0=(0,0x100), din1=(16,0x110);
  - k=1: (8,0x108), (24,0x118);
  - k=15: (15,0x10F), (31,0x11F), with out_last=1.
REQ-031 Natural mode, same frame: k=1 -> din0 real=2, din1 real=3; k=15 -> 30, 31.
REQ-032 Back-pressure: out_ready=0 for 5 cycles at k=3 -> pair 3 held stable, then k=4 follows on the next cycle.
REQ-033 Four frames streamed back-to-back with out_ready=0 -> in_ready falls after 64 accepts.
  - Then out_ready=1 -> frames emerge in order.
  - No sample is lost.
REQ-034 Latency: last sample accepted at edge E -> out_valid=1 after E+1; 16 consecutive pairs follow.
REQ-035 rst_n=0 for 1 cycle after 10 samples are written -> all outputs are at reset values.
  - The next full frame outputs only new data.
